// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/issue sequencer for the 9-bit processor datapath
//
// Purpose:
//   Owns the program counter, fetches instruction and immediate words from a
//   synchronous instruction ROM, presents them on the processor's Din and
//   drives its run input. Retires an instruction on cpu_done, detects the
//   HALT encoding and faults when an instruction runs for WDOG_CYC EXEC
//   cycles without cpu_done.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   pulse: begin execution at START_ADDR (IDLE/HALT/FAULT only)
//   mem_addr    out  ROM address (combinational from state and pc)
//   mem_rdata   in   ROM data, valid one cycle after mem_addr
//   cpu_din     out  processor Din (ROM word in ISSUE/EXEC, else 0)
//   cpu_run     out  processor run
//   cpu_resetn  out  processor reset, active low (~reset)
//   cpu_done    in   processor instruction complete
//   pc          out  program counter
//   retired     out  saturating retired-instruction count
//   busy        out  FETCH/ISSUE/EXEC (and PAUSE)
//   halted      out  HALT state
//   fault       out  FAULT state (watchdog)
//   step        in   single-step advance, present only with SEQ_SINGLE_STEP_EN
//
// Configuration macro:
//   SEQ_SINGLE_STEP_EN - adds the step port and PAUSE state; a retire that
//   would refetch parks in PAUSE until step.

module program_sequencer #(
   parameter int          ADDR_W     = 5,
   parameter int unsigned START_ADDR = 0,
   parameter int          WDOG_CYC   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [8:0]        mem_rdata,
   output logic [8:0]        cpu_din,
   output logic              cpu_run,
   output logic              cpu_resetn,
   input  logic              cpu_done,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       retired,
   output logic              busy,
   output logic              halted,
   output logic              fault
);

   localparam int             WD_W      = $clog2(WDOG_CYC + 1);
   localparam logic [8:0]     HALT_WORD = 9'b000_111_111;
   localparam logic [2:0]     OP_MVI    = 3'b100;
   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALT,
      S_FAULT
`ifdef SEQ_SINGLE_STEP_EN
      ,
      S_PAUSE
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       retired_q, retired_d;
   logic [8:0]        ir_q, ir_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;

   logic              run_s;
   logic              busy_s;
   logic              halted_s;
   logic              fault_s;
   logic              din_sel_s;
   logic [ADDR_W-1:0] pc_inc_s;

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      ir_d      = ir_q;
      wdog_d    = wdog_q;
      pc_inc_s  = (ir_q[8:6] == OP_MVI) ? ADDR_W'(2) : ADDR_W'(1);

      case (state_q)
         S_IDLE, S_HALT, S_FAULT: begin
            if (start) begin
               pc_d      = START_PC;
               retired_d = '0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            // ROM word at pc arrives now; the processor latches it too.
            ir_d    = mem_rdata;
            wdog_d  = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cpu_done) begin
               // MVI consumes the following word as its immediate.
               pc_d = pc_q + pc_inc_s;
               if (retired_q != 16'hFFFF) begin
                  retired_d = retired_q + 16'd1;
               end
               if (ir_q == HALT_WORD) begin
                  state_d = S_HALT;
               end else begin
`ifdef SEQ_SINGLE_STEP_EN
                  state_d = S_PAUSE;
`else
                  state_d = S_FETCH;
`endif
               end
            end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
               // This is the WDOG_CYC-th EXEC cycle without done.
               state_d = S_FAULT;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_PAUSE: begin
            if (step) begin
               state_d = S_FETCH;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= START_PC;
         retired_q <= '0;
         ir_q      <= '0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
         ir_q      <= ir_d;
         wdog_q    <= wdog_d;
      end
   end

   // Output decode
   always_comb begin
      mem_addr  = pc_q;
      run_s     = 1'b0;
      busy_s    = 1'b0;
      halted_s  = 1'b0;
      fault_s   = 1'b0;
      din_sel_s = 1'b0;

      case (state_q)
         S_FETCH: begin
            busy_s = 1'b1;
         end
         S_ISSUE, S_EXEC: begin
            // Prefetch pc+1 in ISSUE so the immediate is on Din during EXEC.
            mem_addr  = pc_q + ADDR_W'(1);
            run_s     = 1'b1;
            busy_s    = 1'b1;
            din_sel_s = 1'b1;
         end
         S_HALT: begin
            halted_s = 1'b1;
         end
         S_FAULT: begin
            fault_s = 1'b1;
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_PAUSE: begin
            busy_s = 1'b1;
         end
`endif
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Status and processor-facing outputs are forced quiet during the reset
   // cycle itself, not only from the following cycle.
   assign cpu_run    = run_s & ~reset;
   assign busy       = busy_s & ~reset;
   assign halted     = halted_s & ~reset;
   assign fault      = fault_s & ~reset;
   assign cpu_din    = (din_sel_s && !reset) ? mem_rdata : 9'd0;
   assign cpu_resetn = ~reset;
   assign pc         = pc_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer

module tb_program_sequencer;

   localparam int         ADDR_W = 5;
   localparam int         DEPTH  = 32;
   localparam int         WDOG   = 4;
   localparam logic [8:0] HALT_W = 9'b000_111_111;
   localparam logic [8:0] W_ADD  = 9'b010_000_001;
   localparam logic [8:0] W_MV   = 9'b001_010_011;
   localparam logic [8:0] W_MVI  = 9'b100_000_000;
`ifdef SEQ_SINGLE_STEP_EN
   localparam int         GAP_EXP = 2;
`else
   localparam int         GAP_EXP = 1;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] mem_addr;
   logic [8:0]        mem_rdata;
   logic [8:0]        cpu_din;
   logic              cpu_run;
   logic              cpu_resetn;
   logic              cpu_done;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       retired;
   logic              busy;
   logic              halted;
   logic              fault;
`ifdef SEQ_SINGLE_STEP_EN
   logic              step;
`endif

   program_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .WDOG_CYC(WDOG)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .cpu_din    (cpu_din),
      .cpu_run    (cpu_run),
      .cpu_resetn (cpu_resetn),
      .cpu_done   (cpu_done),
`ifdef SEQ_SINGLE_STEP_EN
      .step       (step),
`endif
      .pc         (pc),
      .retired    (retired),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault)
   );

   always #5 clock = ~clock;

   // Synchronous instruction ROM
   logic [8:0] rom [DEPTH];
   always @(posedge clock) mem_rdata <= rom[mem_addr];

   typedef struct {
      int         pc;
      logic [8:0] ir;
      logic [8:0] imm;
      int         len;
   } win_t;

   win_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int exec_len(input logic [8:0] ir);
      case (ir[8:6])
         3'b000:         return 1;
         3'b001, 3'b100: return 2;
         default:        return 3;
      endcase
   endfunction

   // Processor model: latches IR on the first run cycle, asserts done on the
   // E-th following cycle unless told to hang.
   int         cpu_cnt = 0;
   logic [8:0] cpu_ir  = '0;
   bit         cpu_hang = 0;
   initial cpu_done = 1'b0;
   always @(posedge clock) begin
      #2;
      if (!cpu_run) begin
         cpu_cnt  = 0;
         cpu_done = 1'b0;
      end else if (cpu_cnt == 0) begin
         cpu_ir   = cpu_din;
         cpu_cnt  = 1;
         cpu_done = 1'b0;
      end else begin
         cpu_done = !cpu_hang && (cpu_cnt == exec_len(cpu_ir));
         cpu_cnt++;
      end
   end

   // Monitor: one record per cpu_run window, popped when run drops.
   bit         prev_run  = 0;
   bit         first_win = 1;
   int         gap       = 0;
   int         w_pc      = 0;
   int         w_len     = 0;
   logic [8:0] w_ir      = '0;
   logic [8:0] w_imm     = '0;
   win_t       ew;
   always @(negedge clock) begin
      if (reset) begin
         prev_run = 0;
         w_len    = 0;
         gap      = 0;
      end else begin
         if (cpu_run) begin
            if (!prev_run) begin
               if (!first_win) chk("run_gap", gap, GAP_EXP);
               first_win = 0;
               w_pc  = int'(pc);
               w_ir  = cpu_din;
               w_len = 1;
            end else begin
               if (w_len == 1) w_imm = cpu_din;
               w_len++;
            end
            gap = 0;
         end else begin
            if (prev_run) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_window: got window at pc %0h expected none", w_pc);
               end else begin
                  ew = sb_q.pop_front();
                  chk("win_pc", w_pc, ew.pc);
                  chk("win_ir", w_ir, ew.ir);
                  chk("win_imm", w_imm, ew.imm);
                  chk("win_len", w_len, ew.len);
               end
            end
            gap++;
         end
         prev_run = cpu_run;
      end
   end

   // Reference model: walks the program by the instruction rules.
   int exp_pc, exp_ret;
   bit exp_halt, exp_fault;
   task automatic model_run(input int max_n, input bit hang);
      int   p;
      win_t w;
      p = 0;
      exp_ret = 0;
      exp_halt = 0;
      exp_fault = 0;
      for (int n = 0; n < max_n; n++) begin
         w.pc  = p;
         w.ir  = rom[p];
         w.imm = rom[(p + 1) % DEPTH];
         if (hang) begin
            w.len = 1 + WDOG;
            sb_q.push_back(w);
            exp_fault = 1;
            break;
         end
         w.len = 1 + exec_len(w.ir);
         sb_q.push_back(w);
         exp_ret++;
         p = (p + ((w.ir[8:6] == 3'b100) ? 2 : 1)) % DEPTH;
         if (w.ir == HALT_W) begin
            exp_halt = 1;
            break;
         end
      end
      exp_pc = p;
   endtask

   task automatic launch(input int max_n, input bit hang);
      model_run(max_n, hang);
      cpu_hang = hang;
      @(posedge clock); #1;
      first_win = 1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("fetch_busy", busy, 1);
      chk("fetch_fault", fault, 0);
      chk("fetch_halted", halted, 0);
      chk("fetch_addr", mem_addr, 0);
      chk("fetch_run", cpu_run, 0);
      @(posedge clock); #1;
      chk("issue_run", cpu_run, 1);
   endtask

   task automatic drain_and_check();
      for (int t = 0; t < 3000; t++) begin
         @(negedge clock); #1;
         if (sb_q.size() == 0) break;
      end
      if (sb_q.size() != 0) begin
         chk("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      chk("end_pc", pc, exp_pc);
      chk("end_retired", retired, exp_ret);
      chk("end_halted", halted, exp_halt);
      chk("end_fault", fault, exp_fault);
      if (exp_halt || exp_fault) chk("end_run", cpu_run, 0);
   endtask

   task automatic pulse_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < DEPTH; i++) rom[i] = 9'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b1;
`endif
      clear_rom();
      mem_rdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_resetn", cpu_resetn, 0);
      chk("rst_run", cpu_run, 0);
      chk("rst_busy", busy, 0);
      chk("rst_din", cpu_din, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_pc", pc, 0);
      chk("idle_retired", retired, 0);
      chk("idle_flags", {busy, halted, fault, cpu_run}, 0);
      chk("idle_resetn", cpu_resetn, 1);

      // MVI immediate then HALT
      clear_rom();
      rom[0] = W_MVI; rom[1] = 9'd5; rom[2] = HALT_W;
      launch(50, 0);
      drain_and_check();

      // Period: ADD, MV, NOP, HALT
      clear_rom();
      rom[0] = W_ADD; rom[1] = W_MV; rom[2] = 9'd0; rom[3] = HALT_W;
      launch(50, 0);
      drain_and_check();

      // Watchdog, then restart out of FAULT
      clear_rom();
      rom[0] = W_ADD;
      launch(50, 1);
      drain_and_check();
      clear_rom();
      rom[1] = HALT_W;
      launch(50, 0);
      drain_and_check();

      // Wrap: MVI at 31 takes its immediate from address 0
      clear_rom();
      rom[0] = 9'd7; rom[31] = 9'b100_001_000;
      launch(32, 0);
      drain_and_check();
      pulse_reset();

      // Reset in the middle of an ADD
      clear_rom();
      rom[2] = W_ADD; rom[3] = HALT_W;
      launch(2, 0);
      drain_and_check();
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("midadd_run", cpu_run, 1);
      reset = 1'b1;
      @(negedge clock); #1;
      chk("midrst_run", cpu_run, 0);
      chk("midrst_resetn", cpu_resetn, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_din", cpu_din, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      chk("postrst_pc", pc, 0);
      chk("postrst_retired", retired, 0);
      chk("postrst_flags", {busy, halted, fault, cpu_run}, 0);

`ifdef SEQ_SINGLE_STEP_EN
      // Single-step: park in PAUSE after the first retire
      clear_rom();
      rom[2] = HALT_W;
      step = 1'b0;
      launch(3, 0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clock); #1;
         if (sb_q.size() == 2) break;
      end
      for (int i = 0; i < 10; i++) begin
         chk("pause_busy", busy, 1);
         chk("pause_run", cpu_run, 0);
         @(negedge clock); #1;
      end
      @(posedge clock); #1;
      first_win = 1;
      step = 1'b1;
      @(posedge clock); #1;
      chk("step_fetch_run", cpu_run, 0);
      chk("step_fetch_addr", mem_addr, 1);
      @(posedge clock); #1;
      chk("step_issue_run", cpu_run, 1);
      drain_and_check();
`endif

      // Randomized programs
      for (int r = 0; r < 8; r++) begin
         logic [2:0] ops [5];
         ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b010; ops[4] = 3'b011;
         for (int i = 0; i < DEPTH; i++) begin
            rom[i] = {ops[$urandom_range(0, 4)], 6'($urandom)};
         end
         if ($urandom_range(0, 3) != 0) rom[$urandom_range(1, DEPTH - 1)] = HALT_W;
         launch(40, $urandom_range(0, 5) == 0);
         drain_and_check();
         if (!(exp_halt || exp_fault)) pulse_reset();
      end

      repeat (3) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
